cells_frame_commit: RTL
=======================

// Module: cells_frame_commit
// PURPOSE
//  Commits the next-state buffer (ram) into the displayed frame buffer (vram) once cells_next_state has
//  finished a generation.
//  - Copies ram[A] -> vram[A] for every cell and clears ram[A] to 0 in the same pass.
//  - Then pulses ready_o, which drives cells_next_state.ready_i to start the next generation.
//  - After reset it runs one clear-only pass, so ram starts empty and the first generation is kicked off.
// PARAMETERS
//  ACTIVE_COLUMNS  640                                      cells per row
//  ACTIVE_ROWS     480                                      rows
//  CELLS           ACTIVE_COLUMNS*ACTIVE_ROWS               total cells (N)
//  ADDR_WIDTH      $clog2(ACTIVE_COLUMNS*ACTIVE_ROWS)       cell address width
//  DATA_WIDTH      2                                        cell state width (0 = empty)
//  COUNT_WIDTH     16                                       generation counter width
// PORTS
//  clk_i              in   1           single clock; every port is synchronous to it
//  reset_ni           in   1           asynchronous, active-low reset
//  start_i            in   1           one-cycle pulse from cells_next_state.done_o: begin commit
//  stall_i            in   1           vram port busy: pause the pass (no read issue, no write)
//  ram_rd_data_i      in   DATA_WIDTH  ram read data, 1-cycle synchronous read latency
//  ram_rd_address_o   out  ADDR_WIDTH  ram read address
//  ram_wr_address_o   out  ADDR_WIDTH  ram write address (clear)
//  ram_wr_data_o      out  DATA_WIDTH  always 0
//  ram_wr_en_o        out  1           ram write strobe
//  vram_wr_address_o  out  ADDR_WIDTH  vram write address
//  vram_wr_data_o     out  DATA_WIDTH  committed cell state
//  vram_wr_en_o       out  1           vram write strobe
//  busy_o             out  1           high in any state except IDLE
//  ready_o            out  1           one-cycle pulse when a pass completes
//  gen_count_o        out  COUNT_WIDTH completed commit passes; wraps modulo 2^COUNT_WIDTH
// BEHAVIOUR
//  Reset (reset_ni low, asynchronous):
//   - state = INIT_CLEAR; address counters, pipeline valid and gen_count_o = 0.
//   - All write enables, ready_o and data outputs = 0; busy_o = 1.
//   - Reset asserted mid-pass aborts the pass and restarts the clear pass from address 0.
//  States:
//   - INIT_CLEAR: writes ram[A] = 0 for A = 0..N-1, one per non-stalled cycle; issues no reads and no
//     vram writes. After A = N-1 -> DONE.
//   - IDLE: busy_o = 0. start_i -> COPY with rd_addr = 0. start_i in any other state is ignored.
//   - COPY: 2-stage pipeline.
//     - Issue stage: when !stall_i and rd_addr < N, drive ram_rd_address_o = rd_addr, set
//       valid_d = 1, addr_d = rd_addr, then rd_addr++.
//     - Write stage, cycle after issue: vram[addr_d] = ram_rd_data_i and ram[addr_d] = 0, both
//       enables high in the same cycle.
//     - If stall_i is high in the write cycle, the data is captured into a hold register and written
//       on the first non-stalled cycle; no new read is issued until the hold register has drained.
//     - When rd_addr == N and the pipeline is empty -> DONE.
//   - DONE: ready_o = 1 for exactly one cycle; gen_count_o++ (COPY passes only, not INIT_CLEAR);
//     -> IDLE.
//  Throughput and latency:
//   - Unstalled: one cell per cycle; a COPY pass takes N+2 cycles from start_i to ready_o.
//   - Stalled: each stall cycle adds exactly one cycle.
//  Hazards and limits:
//   - The ram read (address A) and ram clear (address A-1) fall in the same cycle. The ram is
//     dual-port and the addresses always differ, so there is no read/write hazard.
//   - Addresses never exceed N-1; rd_addr is compared against N at ADDR_WIDTH+1 bits.
//  Idle outputs: write enables are 0 and all addresses/data are 0 whenever not actively writing.
// STRUCTURE
//  Shared package cells_pkg:
//   - typedef enum logic [2:0] {INIT_CLEAR, IDLE, COPY, DONE} commit_state_t
//   - CELL_EMPTY = '0
//   - localparam CELLS
//  Sub-module commit_pipe: issue/hold/write pipeline (valid_d, addr_d, hold register, stall
//  handling); the top level holds only the FSM and counters.
// TESTING (ACTIVE_COLUMNS=4, ACTIVE_ROWS=3, N=12, DATA_WIDTH=2)
//  1. Release reset, no stall -> 12 ram writes of 0 to addr 0..11, zero vram writes, then one
//     ready_o pulse; gen_count_o stays 0.
//  2. Preload ram[k] = k%4, pulse start_i -> vram[k] = k%4 and ram[k] = 0 for all k; ready_o exactly
//     14 cycles after start_i; gen_count_o = 1.
//  3. Same as 2 with stall_i high on cycles 3-5 and 8 after start_i -> identical memory contents,
//     no write while stalled, ready_o 4 cycles later (18).
//  4. Pulse start_i again during COPY -> ignored: still exactly 12 vram writes and one ready_o;
//     gen_count_o increments by 1.
//  5. Drop reset_ni at cell 6 of a COPY -> outputs 0 immediately; a full INIT_CLEAR follows, then
//     ready_o; gen_count_o = 0.
//  6. COUNT_WIDTH=2, run 5 passes -> gen_count_o sequence 1, 2, 3, 0, 1.

Source files
------------

// File: rtl/cells_pkg.sv
// Shared types and constants for the cells frame-commit block.
package cells_pkg;

  localparam int ACTIVE_COLUMNS_DEFAULT = 640;
  localparam int ACTIVE_ROWS_DEFAULT    = 480;
  localparam int CELLS                  = ACTIVE_COLUMNS_DEFAULT * ACTIVE_ROWS_DEFAULT;

  // State value of an empty cell.
  localparam logic [1:0] CELL_EMPTY = 2'b00;

  typedef enum logic [2:0] {
    INIT_CLEAR = 3'd0,
    IDLE       = 3'd1,
    COPY       = 3'd2,
    DONE       = 3'd3
  } commit_state_t;

endpackage

// File: rtl/cells_frame_commit_pipe.sv
// Issue/write pipeline for the frame commit.
// A cell is issued in one cycle and written back the next. A copy cell reads ram and
// writes vram plus a clear of ram. A clear-only cell writes ram only. If the write
// cycle is stalled, the cell (and the ram read data, which is only valid in that
// cycle) is parked in a hold register. The hold register is written on the first
// non-stalled cycle. A new cell may be issued in that same cycle, so each stall
// cycle costs exactly one cycle.
module commit_pipe
  import cells_pkg::*;
#(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 2
) (
  input  logic                  clk_i,
  input  logic                  reset_ni,
  input  logic                  stall_i,
  input  logic                  issue_i,
  input  logic                  copy_i,
  input  logic [ADDR_WIDTH-1:0] issue_addr_i,
  input  logic [DATA_WIDTH-1:0] ram_rd_data_i,
  output logic [ADDR_WIDTH-1:0] ram_rd_address_o,
  output logic [ADDR_WIDTH-1:0] ram_wr_address_o,
  output logic [DATA_WIDTH-1:0] ram_wr_data_o,
  output logic                  ram_wr_en_o,
  output logic [ADDR_WIDTH-1:0] vram_wr_address_o,
  output logic [DATA_WIDTH-1:0] vram_wr_data_o,
  output logic                  vram_wr_en_o,
  output logic                  drained_o
);

  localparam logic [DATA_WIDTH-1:0] L_EMPTY = DATA_WIDTH'(CELL_EMPTY);

  logic                  r_valid_d;
  logic                  r_copy_d;
  logic [ADDR_WIDTH-1:0] r_addr_d;
  logic                  r_hold_valid;
  logic                  r_hold_copy;
  logic [ADDR_WIDTH-1:0] r_hold_addr;
  logic [DATA_WIDTH-1:0] r_hold_data;

  logic                  w_wr_go;
  logic                  w_vram_go;
  logic                  w_wr_copy;
  logic [ADDR_WIDTH-1:0] w_wr_addr;
  logic [DATA_WIDTH-1:0] w_wr_data;

  // Issue stage register and the stall hold register
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      r_valid_d    <= 1'b0;
      r_copy_d     <= 1'b0;
      r_addr_d     <= '0;
      r_hold_valid <= 1'b0;
      r_hold_copy  <= 1'b0;
      r_hold_addr  <= '0;
      r_hold_data  <= L_EMPTY;
    end else begin
      r_valid_d <= issue_i;
      r_copy_d  <= issue_i & copy_i;
      r_addr_d  <= issue_i ? issue_addr_i : '0;
      if (stall_i && r_valid_d) begin
        r_hold_valid <= 1'b1;
        r_hold_copy  <= r_copy_d;
        r_hold_addr  <= r_addr_d;
        r_hold_data  <= r_copy_d ? ram_rd_data_i : L_EMPTY;
      end else if (!stall_i) begin
        r_hold_valid <= 1'b0;
        r_hold_copy  <= 1'b0;
        r_hold_addr  <= '0;
        r_hold_data  <= L_EMPTY;
      end
    end
  end

  // Write stage: pick the source (hold register first) and force idle outputs to 0
  always_comb begin
    w_wr_go = !stall_i && (r_valid_d || r_hold_valid);
    if (r_hold_valid) begin
      w_wr_copy = r_hold_copy;
      w_wr_addr = r_hold_addr;
      w_wr_data = r_hold_data;
    end else begin
      w_wr_copy = r_copy_d;
      w_wr_addr = r_addr_d;
      w_wr_data = ram_rd_data_i;
    end
    w_vram_go = w_wr_go && w_wr_copy;

    ram_rd_address_o  = (issue_i && copy_i) ? issue_addr_i : '0;
    ram_wr_data_o     = L_EMPTY;
    ram_wr_en_o       = w_wr_go;
    ram_wr_address_o  = w_wr_go ? w_wr_addr : '0;
    vram_wr_en_o      = w_vram_go;
    vram_wr_address_o = w_vram_go ? w_wr_addr : '0;
    vram_wr_data_o    = w_vram_go ? w_wr_data : L_EMPTY;
    // Empty after this cycle unless a pending write is held back by stall
    drained_o         = !(stall_i && (r_valid_d || r_hold_valid));
  end

endmodule

// File: rtl/cells_frame_commit.sv
// Frame commit: copies the next-state buffer (ram) into vram and clears ram.
// It then pulses ready_o to start the next generation. After reset it runs a
// clear-only pass first. This level holds the FSM and the counters. The
// issue/hold/write pipeline is in commit_pipe.
module cells_frame_commit
  import cells_pkg::*;
#(
  parameter int ACTIVE_COLUMNS = ACTIVE_COLUMNS_DEFAULT,
  parameter int ACTIVE_ROWS    = ACTIVE_ROWS_DEFAULT,
  parameter int ADDR_WIDTH     = $clog2(ACTIVE_COLUMNS * ACTIVE_ROWS),
  parameter int DATA_WIDTH     = 2,
  parameter int COUNT_WIDTH    = 16
) (
  input  logic                   clk_i,
  input  logic                   reset_ni,
  input  logic                   start_i,
  input  logic                   stall_i,
  input  logic [DATA_WIDTH-1:0]  ram_rd_data_i,
  output logic [ADDR_WIDTH-1:0]  ram_rd_address_o,
  output logic [ADDR_WIDTH-1:0]  ram_wr_address_o,
  output logic [DATA_WIDTH-1:0]  ram_wr_data_o,
  output logic                   ram_wr_en_o,
  output logic [ADDR_WIDTH-1:0]  vram_wr_address_o,
  output logic [DATA_WIDTH-1:0]  vram_wr_data_o,
  output logic                   vram_wr_en_o,
  output logic                   busy_o,
  output logic                   ready_o,
  output logic [COUNT_WIDTH-1:0] gen_count_o
);

  localparam int                 L_CELLS = ACTIVE_COLUMNS * ACTIVE_ROWS;
  // The cell count is compared one bit wider than an address so N itself fits
  localparam logic [ADDR_WIDTH:0] L_END  = (ADDR_WIDTH + 1)'(L_CELLS);
  localparam logic [ADDR_WIDTH:0] L_ONE  = (ADDR_WIDTH + 1)'(1);

  commit_state_t          r_state;
  commit_state_t          w_next_state;
  logic [ADDR_WIDTH:0]    r_addr;
  logic [COUNT_WIDTH-1:0] r_gen_count;

  logic w_active;
  logic w_copy;
  logic w_issue;
  logic w_addr_done;
  logic w_drained;

  // Issue decision: walk the address counter in either pass, except while stalled
  always_comb begin
    w_active    = (r_state == INIT_CLEAR) || (r_state == COPY);
    w_copy      = (r_state == COPY);
    w_addr_done = (r_addr == L_END);
    w_issue     = w_active && !stall_i && (r_addr < L_END);
  end

  commit_pipe #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_pipe (
    .clk_i             (clk_i),
    .reset_ni          (reset_ni),
    .stall_i           (stall_i),
    .issue_i           (w_issue),
    .copy_i            (w_copy),
    .issue_addr_i      (r_addr[ADDR_WIDTH-1:0]),
    .ram_rd_data_i     (ram_rd_data_i),
    .ram_rd_address_o  (ram_rd_address_o),
    .ram_wr_address_o  (ram_wr_address_o),
    .ram_wr_data_o     (ram_wr_data_o),
    .ram_wr_en_o       (ram_wr_en_o),
    .vram_wr_address_o (vram_wr_address_o),
    .vram_wr_data_o    (vram_wr_data_o),
    .vram_wr_en_o      (vram_wr_en_o),
    .drained_o         (w_drained)
  );

  // State register
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      r_state <= INIT_CLEAR;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic: a pass ends once every address is issued and the pipe empties
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      INIT_CLEAR: begin
        if (w_addr_done && w_drained) begin
          w_next_state = DONE;
        end else begin
          w_next_state = INIT_CLEAR;
        end
      end
      IDLE: begin
        if (start_i) begin
          w_next_state = COPY;
        end else begin
          w_next_state = IDLE;
        end
      end
      COPY: begin
        if (w_addr_done && w_drained) begin
          w_next_state = DONE;
        end else begin
          w_next_state = COPY;
        end
      end
      DONE:    w_next_state = IDLE;
      default: w_next_state = INIT_CLEAR;
    endcase
  end

  // Address counter and completed-generation counter
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      r_addr      <= '0;
      r_gen_count <= '0;
    end else begin
      if (w_issue) begin
        r_addr <= r_addr + L_ONE;
      end else if (r_state == DONE) begin
        r_addr <= '0;
      end
      // Only copy passes count as a generation; the clear-only pass does not
      if ((r_state == COPY) && (w_next_state == DONE)) begin
        r_gen_count <= r_gen_count + COUNT_WIDTH'(1);
      end
    end
  end

  // Status outputs decoded from the state register
  always_comb begin
    busy_o      = (r_state != IDLE);
    ready_o     = (r_state == DONE);
    gen_count_o = r_gen_count;
  end

endmodule
